// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front-end: opcode encodings,
// the opcode legality check and the issue FSM state type.
package alu_pkg;

   localparam int unsigned OPC_W = 3;

   localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
   localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
   localparam logic [OPC_W-1:0] OP_MUL = 3'b010;
   localparam logic [OPC_W-1:0] OP_AND = 3'b100;
   localparam logic [OPC_W-1:0] OP_OR  = 3'b101;
   localparam logic [OPC_W-1:0] OP_XOR = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } issue_state_t;

   // The two unused encodings (3'b011, 3'b111) are the only ones with both low bits set.
   function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
      return (op[1:0] != 2'b11);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy.
// Ports:
//   clk, rst      clock, async active-high reset
//   push, wdata   write request and data (ignored when full)
//   pop           read request (ignored when empty); rdata shows the head entry
//   full, empty   occupancy flags derived from the level register
//   level         number of buffered entries, 0..DEPTH
module alu_cmd_fifo #(
   parameter int unsigned W     = 11,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage needs no reset; level/pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_unit.sv
// Command front-end for the combinational ALU: buffers operand/opcode
// commands, issues them one at a time, captures the ALU result and returns it.
// Ports:
//   clk, rst                          clock, async active-high reset
//   cmd_valid/cmd_ready               command handshake (ready = FIFO not full)
//   cmd_op1, cmd_op2, cmd_opcode      command payload
//   alu_operand_1/2, alu_opcode       registered drive of the ALU inputs
//   alu_out, alu_status               ALU result and zero flag
//   res_valid/res_ready               result handshake
//   res_data, res_status, res_err     captured result, zero flag, illegal-opcode flag
//   fifo_level                        buffered command count
module alu_issue_unit
   import alu_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [N-1:0]               cmd_op1,
   input  logic [N-1:0]               cmd_op2,
   input  logic [2:0]                 cmd_opcode,
   output logic [N-1:0]               alu_operand_1,
   output logic [N-1:0]               alu_operand_2,
   output logic [2:0]                 alu_opcode,
   input  logic [2*N-1:0]             alu_out,
   input  logic                       alu_status,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [2*N-1:0]             res_data,
   output logic                       res_status,
   output logic                       res_err,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

   localparam int unsigned FW = 2*N + OPC_W;

   issue_state_t  state;
   issue_state_t  state_nxt;
   logic          pop_c;
   logic          push_c;
   logic          fifo_full;
   logic          fifo_empty;
   logic [FW-1:0] fifo_wdata;
   logic [FW-1:0] fifo_rdata;

   assign fifo_wdata = {cmd_op1, cmd_op2, cmd_opcode};
   assign cmd_ready  = !fifo_full;
   assign push_c     = cmd_valid && !fifo_full;

   alu_cmd_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .wdata (fifo_wdata),
      .pop   (pop_c),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Issue FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state and pop decision; HOLD can hand off directly to the next command.
   always_comb begin
      state_nxt = state;
      pop_c     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop_c     = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (res_ready) begin
               if (!fifo_empty) begin
                  pop_c     = 1'b1;
                  state_nxt = ST_ISSUE;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ALU port registers load on pop and otherwise keep their last command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_operand_1 <= '0;
         alu_operand_2 <= '0;
         alu_opcode    <= '0;
      end else if (pop_c) begin
         {alu_operand_1, alu_operand_2, alu_opcode} <= fifo_rdata;
      end
   end

   // Result capture in ISSUE; release on the result handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_status <= 1'b0;
         res_err    <= 1'b0;
      end else if (state == ST_ISSUE) begin
         res_valid  <= 1'b1;
         res_data   <= alu_out;
         res_status <= alu_status;
         res_err    <= !is_legal_op(alu_opcode);
      end else if (state == ST_HOLD && res_ready) begin
         res_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit with a behavioural ALU.
module tb_alu_issue_unit;
   import alu_pkg::*;

   localparam int unsigned N     = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned RW    = 2*N;
   localparam int unsigned LW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [N-1:0]  cmd_op1;
   logic [N-1:0]  cmd_op2;
   logic [2:0]    cmd_opcode;
   logic [N-1:0]  alu_operand_1;
   logic [N-1:0]  alu_operand_2;
   logic [2:0]    alu_opcode;
   logic [RW-1:0] alu_out;
   logic          alu_status;
   logic          res_valid;
   logic          res_ready;
   logic [RW-1:0] res_data;
   logic          res_status;
   logic          res_err;
   logic [LW-1:0] fifo_level;

   int errors = 0;
   int checks = 0;

   alu_issue_unit #(.N(N), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op1       (cmd_op1),
      .cmd_op2       (cmd_op2),
      .cmd_opcode    (cmd_opcode),
      .alu_operand_1 (alu_operand_1),
      .alu_operand_2 (alu_operand_2),
      .alu_opcode    (alu_opcode),
      .alu_out       (alu_out),
      .alu_status    (alu_status),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .res_status    (res_status),
      .res_err       (res_err),
      .fifo_level    (fifo_level)
   );

   always #5 clk = ~clk;

   // Behavioural combinational ALU sitting downstream of the DUT.
   always_comb begin
      alu_out = '0;
      case (alu_opcode)
         OP_ADD:  alu_out = RW'(alu_operand_1) + RW'(alu_operand_2);
         OP_SUB:  alu_out = RW'(alu_operand_1) - RW'(alu_operand_2);
         OP_MUL:  alu_out = RW'(alu_operand_1) * RW'(alu_operand_2);
         OP_AND:  alu_out = RW'(alu_operand_1 & alu_operand_2);
         OP_OR:   alu_out = RW'(alu_operand_1 | alu_operand_2);
         OP_XOR:  alu_out = RW'(alu_operand_1 ^ alu_operand_2);
         default: alu_out = '0;
      endcase
      alu_status = (alu_out == '0);
   end

   // Backpressure vectors: op1, op2, opcode, expected result.
   logic [3:0] bp_a [5] = '{4'd2, 4'd6, 4'd12, 4'd9, 4'd1};
   logic [3:0] bp_b [5] = '{4'd3, 4'd7, 4'd10, 4'd6, 4'd4};
   logic [2:0] bp_o [5] = '{OP_ADD, OP_MUL, OP_AND, OP_OR, OP_SUB};
   logic [7:0] bp_r [5] = '{8'h05, 8'h2A, 8'h08, 8'h0F, 8'hFD};

   // Streaming ADD vectors and expected sums.
   logic [3:0] st_a [8] = '{4'd1, 4'd15, 4'd8, 4'd0, 4'd7, 4'd10, 4'd12, 4'd3};
   logic [3:0] st_b [8] = '{4'd2, 4'd15, 4'd8, 4'd0, 4'd9, 4'd6,  4'd13, 4'd4};
   logic [7:0] st_r [8] = '{8'h03, 8'h1E, 8'h10, 8'h00, 8'h10, 8'h10, 8'h19, 8'h07};

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_op1    = a;
      cmd_op2    = b;
      cmd_opcode = op;
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
   endtask

   // Wait (bounded) for a result, check it, then accept it for one edge.
   task automatic expect_res(input string tag, input logic [7:0] d, input logic st, input logic er);
      int n = 0;
      while (!res_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_valid"}, 16'(res_valid), 16'd1);
      if (res_valid) begin
         chk({tag, "_data"},   16'(res_data),   16'(d));
         chk({tag, "_status"}, 16'(res_status), 16'(st));
         chk({tag, "_err"},    16'(res_err),    16'(er));
         res_ready = 1'b1;
         @(posedge clk);
         #1;
         res_ready = 1'b0;
      end
   endtask

   initial begin
      int sent;
      int got;
      int cyc;
      int last_cyc;

      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op1    = '0;
      cmd_op2    = '0;
      cmd_opcode = '0;
      res_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res_valid", 16'(res_valid), 16'd0);
      chk("rst_level",     16'(fifo_level), 16'd0);
      chk("rst_cmd_ready", 16'(cmd_ready), 16'd1);
      chk("rst_res_data",  16'(res_data), 16'd0);
      chk("rst_op1",       16'(alu_operand_1), 16'd0);
      chk("rst_opcode",    16'(alu_opcode), 16'd0);
      @(negedge clk);
      rst = 1'b0;

      // Latency: accepted at T, issued at T+1, result valid after T+2.
      push(4'hF, 4'hF, OP_MUL);
      chk("lat_t0_valid", 16'(res_valid), 16'd0);
      chk("lat_t0_level", 16'(fifo_level), 16'd1);
      @(posedge clk);
      #1;
      chk("lat_t1_valid",  16'(res_valid), 16'd0);
      chk("lat_t1_level",  16'(fifo_level), 16'd0);
      chk("lat_t1_op1",    16'(alu_operand_1), 16'hF);
      chk("lat_t1_opcode", 16'(alu_opcode), 16'(OP_MUL));
      @(posedge clk);
      #1;
      chk("lat_t2_valid", 16'(res_valid), 16'd1);
      expect_res("mul", 8'hE1, 1'b0, 1'b0);
      chk("mul_released", 16'(res_valid), 16'd0);

      push(4'd3, 4'd5, OP_SUB);
      expect_res("sub", 8'hFE, 1'b0, 1'b0);
      push(4'd5, 4'd5, OP_XOR);
      expect_res("xor", 8'h00, 1'b1, 1'b0);

      // Backpressure: five back-to-back commands fill the FIFO behind the held result.
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cmd_valid  = 1'b1;
         cmd_op1    = bp_a[i];
         cmd_op2    = bp_b[i];
         cmd_opcode = bp_o[i];
      end
      @(negedge clk);
      chk("bp_level_full", 16'(fifo_level), 16'd4);
      chk("bp_cmd_ready",  16'(cmd_ready), 16'd0);
      cmd_op1    = 4'd15;
      cmd_op2    = 4'd1;
      cmd_opcode = OP_ADD;
      repeat (2) @(negedge clk);
      chk("bp_no_overfill", 16'(fifo_level), 16'd4);
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) expect_res($sformatf("bp%0d", i), bp_r[i], 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("bp_drained_valid", 16'(res_valid), 16'd0);
      chk("bp_drained_level", 16'(fifo_level), 16'd0);

      // Illegal opcodes are issued and flagged.
      push(4'd2, 4'd3, 3'b011);
      expect_res("ill011", 8'h00, 1'b1, 1'b1);
      push(4'd1, 4'd1, 3'b111);
      expect_res("ill111", 8'h00, 1'b1, 1'b1);

      // Streaming: one result every two cycles with res_ready held high.
      res_ready = 1'b1;
      sent      = 0;
      got       = 0;
      cyc       = 0;
      last_cyc  = 0;
      while (got < 8 && cyc < 80) begin
         @(negedge clk);
         if (res_valid) begin
            chk($sformatf("st%0d_data", got), 16'(res_data), 16'(st_r[got]));
            chk($sformatf("st%0d_status", got), 16'(res_status), 16'(st_r[got] == 8'h00));
            chk($sformatf("st%0d_err", got), 16'(res_err), 16'd0);
            if (got > 0) chk($sformatf("st%0d_gap", got), 16'(cyc - last_cyc), 16'd2);
            last_cyc = cyc;
            got++;
         end
         if (sent < 8 && cmd_ready) begin
            cmd_valid  = 1'b1;
            cmd_op1    = st_a[sent];
            cmd_op2    = st_b[sent];
            cmd_opcode = OP_ADD;
            sent++;
         end else begin
            cmd_valid = 1'b0;
         end
         cyc++;
      end
      cmd_valid = 1'b0;
      chk("st_count", 16'(got), 16'd8);
      repeat (4) @(posedge clk);
      #1;
      chk("st_no_dup", 16'(res_valid), 16'd0);
      chk("st_level",  16'(fifo_level), 16'd0);
      res_ready = 1'b0;

      // Reset while holding a result with two commands buffered.
      push(4'd1, 4'd2, OP_ADD);
      push(4'd3, 4'd3, OP_ADD);
      push(4'd4, 4'd4, OP_ADD);
      @(posedge clk);
      #1;
      chk("pre_rst_valid", 16'(res_valid), 16'd1);
      chk("pre_rst_level", 16'(fifo_level), 16'd2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid",     16'(res_valid), 16'd0);
      chk("mid_rst_level",     16'(fifo_level), 16'd0);
      chk("mid_rst_cmd_ready", 16'(cmd_ready), 16'd1);
      chk("mid_rst_data",      16'(res_data), 16'd0);
      chk("mid_rst_status",    16'(res_status), 16'd0);
      chk("mid_rst_err",       16'(res_err), 16'd0);
      chk("mid_rst_op1",       16'(alu_operand_1), 16'd0);
      chk("mid_rst_op2",       16'(alu_operand_2), 16'd0);
      chk("mid_rst_opcode",    16'(alu_opcode), 16'd0);
      @(negedge clk);
      rst       = 1'b0;
      res_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_valid", 16'(res_valid), 16'd0);
      chk("post_rst_level", 16'(fifo_level), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
